// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential 4x4 multiplier.
// State encoding and operand/product widths live here.
package mult_pkg;

  localparam int ITER   = 4;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/result handshake bundle for seq_mult_ctrl.
// master drives operands and consumes results; slave is the multiplier.
interface seq_mult_ctrl_if;
  import mult_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   mcand;
  logic [OP_W-1:0]   mplier;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic [OP_W-1:0]   product_rnd;
  logic              busy;

  modport master (
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, product, product_rnd, busy
  );

  modport slave (
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, product, product_rnd, busy
  );

endinterface

// File: rtl/seq_mult_ctrl_adder.sv
// 4-bit ripple-carry adder with 5-bit operand ports.
// Bit 4 is summed with the final carry; callers use cout for the carry.
module adder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic       cin,
  output logic [4:0] s,
  output logic       cout
);

  logic carry;

  // ripple the carry through the low four bits
  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    s[4] = a[4] ^ b[4] ^ carry;
    cout = carry;
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-add 4x4 unsigned multiplier with optional rounding cycle.
// One shared adder does the partial sums and the final round-half-up.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_ctrl_if.slave bus
);

  state_t state, state_nxt;

  logic [OP_W-1:0]   m_q;
  logic [OP_W-1:0]   q_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   r_q;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] prod_q;
  logic [OP_W-1:0]   rnd_q;

  logic [4:0] add_a;
  logic [4:0] add_b;
  logic       add_cin;
  logic [4:0] add_s;
  logic       add_cout;
  logic       unused_s4;

  logic last_iter;

  adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  assign unused_s4 = add_s[4];
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // next state and adder operand selection
  always_comb begin
    state_nxt = state;
    add_a     = {1'b0, a_q};
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        add_b = q_q[0] ? {1'b0, m_q} : '0;
        if (last_iter) state_nxt = ROUND_EN ? ROUND : DONE;
      end
      ROUND: begin
        add_cin   = q_q[3];
        state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, datapath and held-result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      m_q    <= '0;
      q_q    <= '0;
      a_q    <= '0;
      r_q    <= '0;
      cnt    <= '0;
      prod_q <= '0;
      rnd_q  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m_q <= bus.mcand;
            q_q <= bus.mplier;
            a_q <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          a_q <= {add_cout, add_s[3:1]};
          q_q <= {add_s[0], q_q[3:1]};
          cnt <= cnt + CNT_W'(1);
          if (last_iter && !ROUND_EN) begin
            prod_q <= {add_cout, add_s[3:0], q_q[3:1]};
            rnd_q  <= '0;
          end
        end
        ROUND: begin
          r_q    <= add_s[3:0];
          prod_q <= {a_q, q_q};
          rnd_q  <= add_s[3:0];
        end
        default: ;
      endcase
    end
  end

  // handshake flags decode from state alone
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    unique case (1'b1)
      state == IDLE:  bus.in_ready  = 1'b1;
      state == CALC:  bus.busy      = 1'b1;
      state == ROUND: bus.busy      = 1'b1;
      state == DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.product     = prod_q;
  assign bus.product_rnd = rnd_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: rounding and non-rounding builds side by side.
// Directed table, reset/backpressure sequences, then all operand pairs.
module tb_seq_mult_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_mult_ctrl_if b0 ();
  seq_mult_ctrl_if b1 ();

  seq_mult_ctrl #(.ROUND_EN(1'b0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  seq_mult_ctrl #(.ROUND_EN(1'b1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  logic [1:0]      iv;
  logic [1:0][3:0] mc;
  logic [1:0][3:0] mp;
  logic [1:0]      ordy;
  logic [1:0]      rdy;
  logic [1:0]      ov;
  logic [1:0]      bsy;
  logic [1:0][7:0] pr;
  logic [1:0][3:0] rn;

  assign b0.in_valid  = iv[0];
  assign b0.mcand     = mc[0];
  assign b0.mplier    = mp[0];
  assign b0.out_ready = ordy[0];
  assign b1.in_valid  = iv[1];
  assign b1.mcand     = mc[1];
  assign b1.mplier    = mp[1];
  assign b1.out_ready = ordy[1];

  assign rdy[0] = b0.in_ready;
  assign ov[0]  = b0.out_valid;
  assign bsy[0] = b0.busy;
  assign pr[0]  = b0.product;
  assign rn[0]  = b0.product_rnd;
  assign rdy[1] = b1.in_ready;
  assign ov[1]  = b1.out_valid;
  assign bsy[1] = b1.busy;
  assign pr[1]  = b1.product;
  assign rn[1]  = b1.product_rnd;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_prod(input int a, input int b);
    return 8'(a * b);
  endfunction

  function automatic logic [3:0] ref_rnd(input int d, input int p);
    if (d == 0) return 4'd0;
    return 4'((p / 16) + ((p % 16) >= 8 ? 1 : 0));
  endfunction

  task automatic run_op(input int d, input logic [3:0] a,
                        input logic [3:0] b, input int hold,
                        input bit poke, output int lat,
                        output logic [7:0] p, output logic [3:0] r);
    int w;
    lat = -1;
    @(negedge clk);
    w = 0;
    while (!rdy[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_op", 32'(rdy[d]), 1);
    iv[d] = 1'b1;
    mc[d] = a;
    mp[d] = b;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    mc[d] = 4'($urandom);
    mp[d] = 4'($urandom);
    chk("busy_after_accept", 32'(bsy[d]), 1);
    chk("in_ready_while_busy", 32'(rdy[d]), 0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (ov[d]) begin
        lat = k;
        break;
      end
    end
    p = pr[d];
    r = rn[d];
    for (int k = 0; k < hold; k++) begin
      if (poke) begin
        iv[d] = 1'b1;
        mc[d] = 4'($urandom);
        mp[d] = 4'($urandom);
      end
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(ov[d]), 1);
      chk("hold_product", 32'(pr[d]), 32'(p));
      chk("hold_product_rnd", 32'(rn[d]), 32'(r));
      chk("hold_in_ready", 32'(rdy[d]), 0);
      chk("hold_busy", 32'(bsy[d]), 0);
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    chk("idle_after_done", 32'(rdy[d]), 1);
    chk("out_valid_dropped", 32'(ov[d]), 0);
    chk("product_kept", 32'(pr[d]), 32'(p));
    chk("product_rnd_kept", 32'(rn[d]), 32'(r));
  endtask

  typedef struct {
    int         dut;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
    logic [3:0] rnd;
    int         lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int         lat;
    logic [7:0] p;
    logic [3:0] r;
    logic [7:0] ep;

    vt[0] = '{1, 4'd15, 4'd15, 8'hE1, 4'hE, 5};
    vt[1] = '{1, 4'd13, 4'd11, 8'h8F, 4'h9, 5};
    vt[2] = '{0, 4'd13, 4'd11, 8'h8F, 4'h0, 4};
    vt[3] = '{1, 4'd0,  4'd9,  8'h00, 4'h0, 5};
    vt[4] = '{1, 4'd7,  4'd0,  8'h00, 4'h0, 5};
    vt[5] = '{0, 4'd15, 4'd15, 8'hE1, 4'h0, 4};
    vt[6] = '{1, 4'd9,  4'd9,  8'h51, 4'h5, 5};

    rst_n = 1'b0;
    iv    = 2'b11;
    mc    = '{4'd5, 4'd5};
    mp    = '{4'd6, 4'd6};
    ordy  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_in_ready", 32'(rdy[d]), 1);
      chk("reset_out_valid", 32'(ov[d]), 0);
      chk("reset_busy", 32'(bsy[d]), 0);
      chk("reset_product", 32'(pr[d]), 0);
      chk("reset_product_rnd", 32'(rn[d]), 0);
    end
    @(negedge clk);
    iv    = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("no_accept_in_reset_0", 32'(rdy[0]), 1);
    chk("no_accept_in_reset_1", 32'(rdy[1]), 1);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].dut, vt[i].a, vt[i].b, 1, 1'b0, lat, p, r);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_product", i), 32'(p), 32'(vt[i].prod));
      chk($sformatf("vec%0d_product_rnd", i), 32'(r), 32'(vt[i].rnd));
    end

    run_op(1, 4'd13, 4'd11, 10, 1'b1, lat, p, r);
    chk("backpressure_product", 32'(p), 32'h8F);
    chk("backpressure_rnd", 32'(r), 32'h9);
    run_op(1, 4'd2, 4'd6, 0, 1'b0, lat, p, r);
    chk("after_bp_product", 32'(p), 32'h0C);
    chk("after_bp_rnd", 32'(r), 32'h1);

    @(negedge clk);
    iv[1] = 1'b1;
    mc[1] = 4'd9;
    mp[1] = 4'd9;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_in_ready", 32'(rdy[1]), 1);
    chk("midreset_busy", 32'(bsy[1]), 0);
    chk("midreset_product", 32'(pr[1]), 0);
    chk("midreset_product_rnd", 32'(rn[1]), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("midreset_no_out_valid", 32'(ov[1]), 0);
      @(posedge clk);
      #1;
    end
    run_op(1, 4'd3, 4'd5, 0, 1'b0, lat, p, r);
    chk("post_reset_latency", 32'(lat), 5);
    chk("post_reset_product", 32'(p), 32'h0F);
    chk("post_reset_rnd", 32'(r), 32'h1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        run_op(d, 4'(i / 16), 4'(i % 16), int'($urandom_range(0, 3)),
               1'($urandom), lat, p, r);
        ep = ref_prod(i / 16, i % 16);
        chk($sformatf("all_d%0d_%0d_latency", d, i), 32'(lat),
            (d == 1) ? 32'd5 : 32'd4);
        chk($sformatf("all_d%0d_%0d_product", d, i), 32'(p), 32'(ep));
        chk($sformatf("all_d%0d_%0d_rnd", d, i), 32'(r),
            32'(ref_rnd(d, int'(ep))));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
